// File: rtl/cache_def.sv
// Shared definitions for the L1 replacement-policy unit: geometry, PLRU entry
// type and the tree pseudo-LRU decode/update functions.
package cache_def;

    localparam int unsigned DEPTH_L1     = 1024;
    localparam int unsigned WAYS_L1      = 4;
    localparam int unsigned INDEX_L1     = 10;
    localparam int unsigned INDEX_WAY_L1 = 2;

    // b0 = root, b1 = ways 0/1, b2 = ways 2/3
    typedef logic [2:0] plru_bits_t;
    typedef logic [INDEX_WAY_L1-1:0] way_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } plru_state_e;

    function automatic way_t plru_victim(plru_bits_t bits);
        if (!bits[0]) begin
            return bits[1] ? 2'd1 : 2'd0;
        end
        return bits[2] ? 2'd3 : 2'd2;
    endfunction

    // Point the tree away from the accessed way; other bits are kept.
    function automatic plru_bits_t plru_touch(plru_bits_t bits, way_t way);
        plru_bits_t nxt;
        nxt = bits;
        case (way)
            2'd0:    begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
            2'd1:    begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
            2'd2:    begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
            default: begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/plru_ram.sv
// Simple dual-port RAM, one write port and one synchronous read port
// (read returns the old contents on a same-address write).
module plru_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cache_plru.sv
// Tree pseudo-LRU replacement unit for the 4-way L1: per-set state sweep on
// reset, 1-cycle victim lookup with invalid-way priority, forwarded updates.
module cache_plru
    import cache_def::*;
#(
    parameter int unsigned DEPTH = DEPTH_L1,
    parameter int unsigned WAYS  = WAYS_L1,
    parameter int unsigned IDX_W = INDEX_L1,
    parameter int unsigned WAY_W = INDEX_WAY_L1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lookup_i,
    input  logic [IDX_W-1:0] lookup_index_i,
    input  logic [WAYS-1:0]  lookup_valid_vec_i,
    input  logic             upd_i,
    input  logic [IDX_W-1:0] upd_index_i,
    input  logic [WAY_W-1:0] upd_way_i,
    output logic [WAY_W-1:0] victim_way_o,
    output logic             victim_valid_o,
    output logic             victim_free_o,
    output logic             ready_o
);

    if (WAYS != 4 || WAY_W != 2) begin : g_bad_cfg
        $error("cache_plru: tree encoding supports exactly 4 ways");
    end

    plru_state_e      state_q, state_d;
    logic [IDX_W-1:0] cnt_q;
    logic             sweep;

    logic             upd_v_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic [WAY_W-1:0] upd_way_q;
    logic             lk_v_q;
    logic [IDX_W-1:0] lk_idx_q;
    logic [WAYS-1:0]  lk_vec_q;
    logic             wr1_v_q;
    logic [IDX_W-1:0] wr1_idx_q;
    plru_bits_t       wr1_data_q;
    logic [WAY_W-1:0] hold_way_q;
    logic             hold_free_q;

    plru_bits_t       lk_rdata, upd_rdata, upd_base, upd_new, wdata, lk_bits;
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [WAY_W-1:0] vic_way;
    logic             vic_free;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        sweep   = 1'b0;
        ready_o = 1'b0;
        case (state_q)
            ST_INIT: sweep   = 1'b1;
            default: ready_o = 1'b1;
        endcase
    end

    // Two copies of the state so lookups and update reads each get a read port.
    plru_ram #(.DEPTH(DEPTH), .AW(IDX_W), .DW(3)) u_ram_lookup (
        .clk(clk_i), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(lookup_index_i), .rdata(lk_rdata)
    );

    plru_ram #(.DEPTH(DEPTH), .AW(IDX_W), .DW(3)) u_ram_upd (
        .clk(clk_i), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(upd_index_i), .rdata(upd_rdata)
    );

    // The write committed last edge is not yet visible in the RAM read data.
    always_comb begin
        upd_base = (wr1_v_q && wr1_idx_q == upd_idx_q) ? wr1_data_q : upd_rdata;
        upd_new  = plru_touch(upd_base, upd_way_q);
        we       = sweep || upd_v_q;
        waddr    = sweep ? cnt_q : upd_idx_q;
        wdata    = sweep ? 3'b000 : upd_new;
    end

    // Lookup sees the newest of: this cycle's write, last cycle's write, RAM.
    always_comb begin
        if (upd_v_q && upd_idx_q == lk_idx_q) begin
            lk_bits = upd_new;
        end else if (wr1_v_q && wr1_idx_q == lk_idx_q) begin
            lk_bits = wr1_data_q;
        end else begin
            lk_bits = lk_rdata;
        end
        vic_free = (lk_vec_q != '1);
        if (!lk_vec_q[0])      vic_way = 2'd0;
        else if (!lk_vec_q[1]) vic_way = 2'd1;
        else if (!lk_vec_q[2]) vic_way = 2'd2;
        else if (!lk_vec_q[3]) vic_way = 2'd3;
        else                   vic_way = plru_victim(lk_bits);
        victim_valid_o = lk_v_q;
        victim_way_o   = lk_v_q ? vic_way  : hold_way_q;
        victim_free_o  = lk_v_q ? vic_free : hold_free_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            upd_v_q     <= 1'b0;
            upd_idx_q   <= '0;
            upd_way_q   <= '0;
            lk_v_q      <= 1'b0;
            lk_idx_q    <= '0;
            lk_vec_q    <= '0;
            wr1_v_q     <= 1'b0;
            wr1_idx_q   <= '0;
            wr1_data_q  <= '0;
            hold_way_q  <= '0;
            hold_free_q <= 1'b0;
        end else begin
            if (sweep) begin
                cnt_q <= (cnt_q == IDX_W'(DEPTH - 1)) ? '0 : cnt_q + IDX_W'(1);
            end
            upd_v_q    <= upd_i && (state_q == ST_RUN);
            upd_idx_q  <= upd_index_i;
            upd_way_q  <= upd_way_i;
            lk_v_q     <= lookup_i && (state_q == ST_RUN);
            lk_idx_q   <= lookup_index_i;
            lk_vec_q   <= lookup_valid_vec_i;
            wr1_v_q    <= we;
            wr1_idx_q  <= waddr;
            wr1_data_q <= wdata;
            if (lk_v_q) begin
                hold_way_q  <= vic_way;
                hold_free_q <= vic_free;
            end
        end
    end

endmodule

// File: tb/tb_cache_plru.sv
// Directed bench for cache_plru: reset sweep timing, PLRU decode/update,
// invalid-way priority, forwarding and reset restart.
module tb_cache_plru;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       lookup_i;
    logic [9:0] lookup_index_i;
    logic [3:0] lookup_valid_vec_i;
    logic       upd_i;
    logic [9:0] upd_index_i;
    logic [1:0] upd_way_i;
    logic [1:0] victim_way_o;
    logic       victim_valid_o;
    logic       victim_free_o;
    logic       ready_o;

    int errors = 0;
    int checks = 0;

    cache_plru dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lookup_i(lookup_i), .lookup_index_i(lookup_index_i),
        .lookup_valid_vec_i(lookup_valid_vec_i),
        .upd_i(upd_i), .upd_index_i(upd_index_i), .upd_way_i(upd_way_i),
        .victim_way_o(victim_way_o), .victim_valid_o(victim_valid_o),
        .victim_free_o(victim_free_o), .ready_o(ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset for two cycles, then count INIT cycles while poking lookup/upd.
    task automatic reset_sweep(input string tag);
        int n;
        int bad;
        rst_i = 1'b1; lookup_i = 1'b0; upd_i = 1'b0;
        tick(); tick();
        check({tag, "_rst_ready"}, 32'(ready_o), 0);
        check({tag, "_rst_valid"}, 32'(victim_valid_o), 0);
        check({tag, "_rst_way"},   32'(victim_way_o), 0);
        check({tag, "_rst_free"},  32'(victim_free_o), 0);
        rst_i = 1'b0;
        lookup_i = 1'b1; lookup_index_i = 10'd5; lookup_valid_vec_i = 4'b0000;
        upd_i = 1'b1; upd_index_i = 10'd5; upd_way_i = 2'd3;
        n = 0; bad = 0;
        while (ready_o !== 1'b1 && n < 2000) begin
            if (victim_valid_o !== 1'b0 || victim_way_o !== 2'd0 || victim_free_o !== 1'b0)
                bad++;
            n++;
            tick();
        end
        check({tag, "_init_len"}, 32'(n), 1024);
        check({tag, "_init_outs"}, 32'(bad), 0);
        check({tag, "_init_novalid"}, 32'(victim_valid_o), 0);
        lookup_i = 1'b0; upd_i = 1'b0;
    endtask

    task automatic upd(input logic [9:0] idx, input logic [1:0] way);
        upd_i = 1'b1; upd_index_i = idx; upd_way_i = way;
        tick();
        upd_i = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [9:0] idx, input logic [3:0] vec,
                          input logic [1:0] exp_way, input logic exp_free);
        lookup_i = 1'b1; lookup_index_i = idx; lookup_valid_vec_i = vec;
        tick();
        lookup_i = 1'b0;
        check({tag, "_valid"}, 32'(victim_valid_o), 1);
        check({tag, "_way"},   32'(victim_way_o), 32'(exp_way));
        check({tag, "_free"},  32'(victim_free_o), 32'(exp_free));
    endtask

    initial begin
        int bad;
        rst_i = 1'b1; lookup_i = 1'b0; upd_i = 1'b0;
        lookup_index_i = '0; lookup_valid_vec_i = 4'hf; upd_index_i = '0; upd_way_i = '0;

        reset_sweep("por");

        // Fresh set (the INIT-time update to set 5 must have been ignored)
        lookup("fresh5", 10'd5, 4'hf, 2'd0, 1'b0);

        // Hold when not valid
        lookup("idx7_pre", 10'd7, 4'hf, 2'd0, 1'b0);
        upd(10'd7, 2'd0); upd(10'd7, 2'd1); upd(10'd7, 2'd2); upd(10'd7, 2'd3);
        lookup("seq7_a", 10'd7, 4'hf, 2'd0, 1'b0);
        upd(10'd7, 2'd0);
        lookup("seq7_b", 10'd7, 4'hf, 2'd2, 1'b0);
        tick();
        check("hold_valid", 32'(victim_valid_o), 0);
        check("hold_way",   32'(victim_way_o), 2);

        // Right pair, b2=1 -> way3
        upd(10'd20, 2'd2); upd(10'd20, 2'd0);
        lookup("idx20", 10'd20, 4'hf, 2'd3, 1'b0);

        // Invalid-way priority overrides PLRU
        upd(10'd9, 2'd2);
        lookup("inv9", 10'd9, 4'b1011, 2'd2, 1'b1);
        lookup("inv9_w0", 10'd9, 4'b1110, 2'd0, 1'b1);

        // Same-cycle update and lookup, same index, then back-to-back update
        upd_i = 1'b1; upd_index_i = 10'd3; upd_way_i = 2'd0;
        lookup_i = 1'b1; lookup_index_i = 10'd3; lookup_valid_vec_i = 4'hf;
        tick();
        lookup_i = 1'b0;
        upd_index_i = 10'd3; upd_way_i = 2'd2;
        check("fwd3_valid", 32'(victim_valid_o), 1);
        check("fwd3_way", 32'(victim_way_o), 2);
        tick();
        upd_i = 1'b0;
        lookup("fwd3_b2b", 10'd3, 4'hf, 2'd1, 1'b0);

        // Different indices in the same cycle are independent
        upd_i = 1'b1; upd_index_i = 10'd11; upd_way_i = 2'd0;
        lookup_i = 1'b1; lookup_index_i = 10'd12; lookup_valid_vec_i = 4'hf;
        tick();
        upd_i = 1'b0; lookup_i = 1'b0;
        check("diff12_way", 32'(victim_way_o), 0);
        lookup("diff11", 10'd11, 4'hf, 2'd2, 1'b0);

        // Reset mid-sweep at cycle 500
        rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
        repeat (500) tick();
        check("mid_sweep_ready", 32'(ready_o), 0);
        reset_sweep("midsweep");

        // Dirty some sets, then reset during RUN
        upd(10'd7, 2'd0); upd(10'd3, 2'd0); upd(10'd20, 2'd2); upd(10'd20, 2'd0);
        lookup("pre_rst7", 10'd7, 4'hf, 2'd2, 1'b0);
        lookup_i = 1'b1; lookup_index_i = 10'd7;
        reset_sweep("midrun");

        // Every set must decode to way 0 after the restart
        bad = 0;
        lookup_i = 1'b1; lookup_valid_vec_i = 4'hf;
        for (int i = 0; i < 1024; i++) begin
            lookup_index_i = 10'(i);
            tick();
            if (victim_valid_o !== 1'b1 || victim_way_o !== 2'd0 || victim_free_o !== 1'b0)
                bad++;
        end
        lookup_i = 1'b0;
        check("all_sets_way0", 32'(bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
